// File: rtl/re_demapper_pkg.sv
// re_pkg: shared constants, FSM states and read-pipeline tag for the RE demapper
package re_pkg;
    localparam int TOTAL_SC    = 1200;
    localparam int SC_PER_RB   = 12;
    localparam int DMRS_PER_RB = 6;
    typedef enum logic [1:0] {IDLE, RD_DMRS, RD_DATA, DRAIN} state_e;
    typedef struct packed {
        logic        is_dmrs;
        logic [10:0] idx;
        logic [3:0]  sym;
        logic        last;
    } tag_t;
endpackage

// File: rtl/re_demapper_if.sv
// re_demapper_if: grid read port and output stream of the RE demapper
interface re_demapper_if #(parameter int DATA_LEN = 18);
    logic                       Rd_En;
    logic [3:0]                 Rd_Sym;
    logic [10:0]                Rd_Addr;
    logic signed [DATA_LEN-1:0] Rd_I, Rd_Q, Out_I, Out_Q;
    logic                       Out_Valid, Out_Ready, Out_Is_DMRS;
    logic [10:0]                Out_Idx;
    logic [3:0]                 Out_Sym;
    modport master (output Rd_En, Rd_Sym, Rd_Addr, Out_I, Out_Q, Out_Valid, Out_Is_DMRS, Out_Idx, Out_Sym,
                    input Rd_I, Rd_Q, Out_Ready);
    modport slave (input Rd_En, Rd_Sym, Rd_Addr, Out_I, Out_Q, Out_Valid, Out_Is_DMRS, Out_Idx, Out_Sym,
                   output Rd_I, Rd_Q, Out_Ready);
endinterface

// File: rtl/re_demap_skid_fifo.sv
// re_demap_skid_fifo: 2-entry sample+tag buffer exposing its occupancy for read credit
module re_demap_skid_fifo import re_pkg::*; #(parameter int DW = 18) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic                 rd,
    input  logic signed [DW-1:0] din_re,
    input  logic signed [DW-1:0] din_im,
    input  tag_t                 din_tag,
    output logic signed [DW-1:0] dout_re,
    output logic signed [DW-1:0] dout_im,
    output tag_t                 dout_tag,
    output logic                 valid,
    output logic [1:0]           cnt
);
    logic signed [DW-1:0] re_q [2], re_d [2], im_q [2], im_d [2];
    tag_t                 tg_q [2], tg_d [2];
    logic                 wp_q, wp_d, rp_q, rp_d;
    logic [1:0]           cnt_q, cnt_d;
    always_comb begin
        re_d = re_q;
        im_d = im_q;
        tg_d = tg_q;
        wp_d = wr ? ~wp_q : wp_q;
        rp_d = rd ? ~rp_q : rp_q;
        cnt_d = cnt_q + {1'b0, wr} - {1'b0, rd};
        if (wr) begin
            re_d[wp_q] = din_re;
            im_d[wp_q] = din_im;
            tg_d[wp_q] = din_tag;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            re_q  <= '{default: '0};
            im_q  <= '{default: '0};
            tg_q  <= '{default: '0};
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            re_q  <= re_d;
            im_q  <= im_d;
            tg_q  <= tg_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout_re  = re_q[rp_q];
    assign dout_im  = im_q[rp_q];
    assign dout_tag = tg_q[rp_q];
    assign valid    = cnt_q != 2'd0;
    assign cnt      = cnt_q;
endmodule

// File: rtl/re_demapper.sv
// re_demapper: reads a slot's DMRS and data REs from the grid and streams them with their tags
module re_demapper import re_pkg::*; #(parameter int Data_Len = 18) (
    input  logic         CLK_DEM,
    input  logic         RST_DEM,
    input  logic         Start,
    input  logic [10:0]  N_sc,
    input  logic [6:0]   N_rb,
    input  logic [3:0]   Sym_Start,
    input  logic [3:0]   Sym_End,
    output logic         Sym_Done,
    output logic         Dem_Done,
    output logic         Busy,
    output logic         Cfg_Err,
    re_demapper_if.master bus
);
    state_e               state_q, state_d;
    logic [10:0]          n_sc_q, n_sc_d, n_data_q, n_data_d, k_q, k_d, cand_data;
    logic [9:0]           n_dmrs_q, n_dmrs_d;
    logic [3:0]           sym_end_q, sym_end_d, sym_q, sym_d;
    logic                 in_flight_q, in_flight_d, cfg_err_q, cfg_err_d;
    tag_t                 tag_q, tag_d, head_tag;
    logic signed [Data_Len-1:0] head_re, head_im;
    logic [11:0]          sum;
    logic [1:0]           cnt;
    logic                 head_valid, pop, credit, rd_en, last, bad, accept;
    always_comb begin
        cand_data   = 11'(N_rb * SC_PER_RB);
        sum         = {1'b0, N_sc} + {1'b0, cand_data};
        bad         = N_rb == 7'd0 || sum > 12'(TOTAL_SC) || Sym_End < Sym_Start || Sym_End > 4'd13;
        pop         = head_valid && bus.Out_Ready;
        // credit counts the read in flight so the buffer can never overflow
        credit      = (cnt + {1'b0, in_flight_q} - {1'b0, pop}) < 2'd2;
        Dem_Done    = state_q == DRAIN && cnt == 2'd0 && !in_flight_q;
        Busy        = state_q != IDLE && !Dem_Done;
        accept      = Start && !Busy;
        rd_en       = (state_q == RD_DMRS || state_q == RD_DATA) && credit;
        last        = state_q == RD_DMRS ? k_q == {1'b0, n_dmrs_q} - 11'd1 : k_q == n_data_q - 11'd1;
        state_d     = Dem_Done ? IDLE : state_q;
        n_sc_d      = n_sc_q;
        n_data_d    = n_data_q;
        n_dmrs_d    = n_dmrs_q;
        sym_end_d   = sym_end_q;
        k_d         = k_q;
        sym_d       = sym_q;
        cfg_err_d   = accept && bad;
        in_flight_d = rd_en;
        tag_d       = rd_en ? '{is_dmrs: state_q == RD_DMRS, idx: k_q, sym: sym_q, last: last} : tag_q;
        if (rd_en) begin
            k_d = last ? 11'd0 : k_q + 11'd1;
            if (last) begin
                sym_d   = sym_q + 4'd1;
                state_d = sym_q == sym_end_q ? DRAIN : RD_DATA;
            end
        end
        if (accept && !bad) begin
            n_sc_d    = N_sc;
            n_data_d  = cand_data;
            n_dmrs_d  = 10'(N_rb * DMRS_PER_RB);
            sym_end_d = Sym_End;
            k_d       = 11'd0;
            sym_d     = Sym_Start;
            state_d   = RD_DMRS;
        end
    end
    always_ff @(posedge CLK_DEM) begin
        if (RST_DEM) begin
            state_q     <= IDLE;
            n_sc_q      <= '0;
            n_data_q    <= '0;
            n_dmrs_q    <= '0;
            sym_end_q   <= '0;
            k_q         <= '0;
            sym_q       <= '0;
            in_flight_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            n_sc_q      <= n_sc_d;
            n_data_q    <= n_data_d;
            n_dmrs_q    <= n_dmrs_d;
            sym_end_q   <= sym_end_d;
            k_q         <= k_d;
            sym_q       <= sym_d;
            in_flight_q <= in_flight_d;
            cfg_err_q   <= cfg_err_d;
            tag_q       <= tag_d;
        end
    end
    re_demap_skid_fifo #(.DW(Data_Len)) u_fifo (
        .clk      (CLK_DEM),
        .rst      (RST_DEM),
        .wr       (in_flight_q),
        .rd       (pop),
        .din_re   (bus.Rd_I),
        .din_im   (bus.Rd_Q),
        .din_tag  (tag_q),
        .dout_re  (head_re),
        .dout_im  (head_im),
        .dout_tag (head_tag),
        .valid    (head_valid),
        .cnt      (cnt)
    );
    assign bus.Rd_En       = rd_en;
    assign bus.Rd_Sym      = rd_en ? sym_q : 4'd0;
    assign bus.Rd_Addr     = rd_en ? n_sc_q + (state_q == RD_DMRS ? {k_q[9:0], 1'b0} : k_q) : 11'd0;
    assign bus.Out_I       = head_re;
    assign bus.Out_Q       = head_im;
    assign bus.Out_Valid   = head_valid;
    assign bus.Out_Is_DMRS = head_tag.is_dmrs;
    assign bus.Out_Idx     = head_tag.idx;
    assign bus.Out_Sym     = head_tag.sym;
    assign Sym_Done        = pop && head_tag.last;
    assign Cfg_Err         = cfg_err_q;
endmodule

// File: tb/tb_re_demapper.sv
// tb_re_demapper: directed and randomized slots checked against a queue-based model of the demapper
module tb_re_demapper;
    localparam int DL = 18;
    typedef struct {
        logic is_dmrs;
        int   idx;
        int   sym;
        int   addr;
        logic last;
    } re_t;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [10:0] n_sc = '0;
    logic [6:0]  n_rb = '0;
    logic [3:0]  sym_start = '0, sym_end = '0;
    logic        sym_done, dem_done, busy, cfg_err;
    int          checks = 0, failures = 0;
    logic signed [DL-1:0] gi [14][1200], gq [14][1200];
    re_demapper_if #(.DATA_LEN(DL)) bus ();
    re_demapper #(.Data_Len(DL)) dut (
        .CLK_DEM   (clk),
        .RST_DEM   (rst),
        .Start     (start),
        .N_sc      (n_sc),
        .N_rb      (n_rb),
        .Sym_Start (sym_start),
        .Sym_End   (sym_end),
        .Sym_Done  (sym_done),
        .Dem_Done  (dem_done),
        .Busy      (busy),
        .Cfg_Err   (cfg_err),
        .bus       (bus.master)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.Rd_En && bus.Rd_Sym < 4'd14 && bus.Rd_Addr < 11'd1200) begin
            bus.Rd_I <= gi[bus.Rd_Sym][bus.Rd_Addr];
            bus.Rd_Q <= gq[bus.Rd_Sym][bus.Rd_Addr];
        end
    end
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_zero(string pfx);
        check({pfx, "_rd_en"}, bus.Rd_En, 0);
        check({pfx, "_rd_sym"}, bus.Rd_Sym, 0);
        check({pfx, "_rd_addr"}, bus.Rd_Addr, 0);
        check({pfx, "_out_valid"}, bus.Out_Valid, 0);
        check({pfx, "_out_i"}, bus.Out_I, 0);
        check({pfx, "_out_q"}, bus.Out_Q, 0);
        check({pfx, "_out_dmrs"}, bus.Out_Is_DMRS, 0);
        check({pfx, "_out_idx"}, bus.Out_Idx, 0);
        check({pfx, "_out_sym"}, bus.Out_Sym, 0);
        check({pfx, "_sym_done"}, sym_done, 0);
        check({pfx, "_dem_done"}, dem_done, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_cfg_err"}, cfg_err, 0);
    endtask
    task automatic pulse_start(int nsc, int nrb, int ss, int se);
        @(posedge clk); #1;
        start = 1'b1;
        n_sc = 11'(nsc);
        n_rb = 7'(nrb);
        sym_start = 4'(ss);
        sym_end = 4'(se);
        @(posedge clk); #1;
        start = 1'b0;
    endtask
    task automatic run_slot(int nsc, int nrb, int ss, int se, int pct, bit mid_start);
        re_t exp_q[$], rd_q[$], e;
        int issued = 0, xfers = 0, nsd = 0, c = 0, first_v = 0, total;
        bit fin = 0, stall = 0;
        logic signed [DL-1:0] h_i = '0, h_q = '0;
        logic h_d = 1'b0;
        logic [10:0] h_idx = '0;
        logic [3:0] h_sym = '0;
        for (int k = 0; k < 6 * nrb; k++) exp_q.push_back('{1'b1, k, ss, nsc + 2 * k, k == 6 * nrb - 1});
        for (int s = ss + 1; s <= se; s++)
            for (int k = 0; k < 12 * nrb; k++) exp_q.push_back('{1'b0, k, s, nsc + k, k == 12 * nrb - 1});
        rd_q = exp_q;
        total = exp_q.size();
        pulse_start(nsc, nrb, ss, se);
        while (!fin && c < 20000) begin
            c++;
            start = mid_start && c == 20;
            if (start) n_rb = 7'd0;
            bus.Out_Ready = $urandom_range(99) < pct;
            #1;
            if (c == 1) check("busy_t1", busy, 1);
            if (bus.Rd_En) begin
                issued++;
                if (rd_q.size() == 0) check("rd_extra", 1, 0);
                else begin
                    e = rd_q.pop_front();
                    check("rd_sym", bus.Rd_Sym, e.sym);
                    check("rd_addr", bus.Rd_Addr, e.addr);
                end
            end
            if (stall) begin
                check("hold_i", bus.Out_I, h_i);
                check("hold_q", bus.Out_Q, h_q);
                check("hold_dmrs", bus.Out_Is_DMRS, h_d);
                check("hold_idx", bus.Out_Idx, h_idx);
                check("hold_sym", bus.Out_Sym, h_sym);
            end
            if (bus.Out_Valid && first_v == 0) first_v = c;
            if (bus.Out_Valid && bus.Out_Ready) begin
                xfers++;
                if (exp_q.size() == 0) check("out_extra", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("out_i", bus.Out_I, gi[e.sym][e.addr]);
                    check("out_q", bus.Out_Q, gq[e.sym][e.addr]);
                    check("out_dmrs", bus.Out_Is_DMRS, e.is_dmrs);
                    check("out_idx", bus.Out_Idx, e.idx);
                    check("out_sym", bus.Out_Sym, e.sym);
                    check("sym_done", sym_done, e.last);
                    nsd += int'(e.last);
                end
            end else check("sym_done_idle", sym_done, 0);
            check("outstanding_le2", issued - xfers <= 2, 1);
            check("cfg_err_busy", cfg_err, 0);
            if (dem_done) begin
                fin = 1;
                check("dem_busy", busy, 0);
                check("dem_valid", bus.Out_Valid, 0);
                check("dem_out_left", exp_q.size(), 0);
                check("dem_rd_left", rd_q.size(), 0);
                if (pct >= 100) check("dem_cycle", c, 3 + total);
            end else check("busy_slot", busy, 1);
            stall = bus.Out_Valid && !bus.Out_Ready;
            h_i = bus.Out_I;
            h_q = bus.Out_Q;
            h_d = bus.Out_Is_DMRS;
            h_idx = bus.Out_Idx;
            h_sym = bus.Out_Sym;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("slot_finished", fin, 1);
        check("first_valid_t3", first_v, 3);
        check("sym_done_count", nsd, se - ss + 1);
        check("xfer_count", xfers, total);
        #1;
        check("dem_pulse_once", dem_done, 0);
        check("idle_busy", busy, 0);
    endtask
    task automatic cfg_reject(int nsc, int nrb, int ss, int se);
        pulse_start(nsc, nrb, ss, se);
        #1;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        check("cfg_err_rd", bus.Rd_En, 0);
        @(posedge clk); #2;
        check("cfg_err_clear", cfg_err, 0);
        check("cfg_err_idle", busy, 0);
    endtask
    initial begin
        int w, nrb, ss, se, nsc;
        for (int s = 0; s < 14; s++)
            for (int a = 0; a < 1200; a++) begin
                gi[s][a] = DL'($urandom);
                gq[s][a] = DL'($urandom);
            end
        bus.Out_Ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("post_reset");
        bus.Out_Ready = 1'b1;
        run_slot(100, 2, 2, 4, 100, 0);
        run_slot(100, 2, 2, 4, 30, 0);
        run_slot(1188, 1, 0, 1, 100, 0);
        cfg_reject(1189, 1, 0, 1);
        cfg_reject(0, 0, 0, 1);
        cfg_reject(0, 1, 5, 4);
        cfg_reject(0, 1, 3, 14);
        run_slot(40, 3, 5, 5, 60, 0);
        run_slot(100, 2, 2, 4, 50, 1);
        for (int i = 0; i < 3; i++) begin
            nrb = $urandom_range(4, 1);
            ss = $urandom_range(13, 0);
            se = $urandom_range(13, ss);
            nsc = $urandom_range(1200 - 12 * nrb, 0);
            run_slot(nsc, nrb, ss, se, $urandom_range(100, 30), 0);
        end
        bus.Out_Ready = 1'b1;
        pulse_start(100, 2, 2, 4);
        w = 0;
        while (!(bus.Rd_En && bus.Rd_Sym == 4'd3) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("reach_rd_data", w < 200, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("mid_reset");
        rst = 1'b0;
        run_slot(100, 2, 2, 4, 100, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/re_demapper.md
# re_demapper

Receive-side counterpart of the PUSCH resource-element mapper. It reads one slot's allocated subcarriers back out of the frequency-domain grid memory (1200 subcarriers × up to 14 symbols), splits DMRS REs from data REs and streams them, with their allocation index, to the channel estimator and equalizer. Reads are issued one RE per cycle over a 1-cycle-latency grid read port. Output is a valid/ready stream, so a stalling consumer throttles the reads.

## Interface
- `Data_Len`, 18: width of each I/Q sample in the grid and on the output.
- `CLK_DEM` in 1: clock, rising edge.
- `RST_DEM` in 1: synchronous, active-high reset.
- `Start` in 1: single-cycle pulse that latches the configuration and begins a slot. Ignored while `Busy`.
- `N_sc` in 11: first allocated subcarrier.
- `N_rb` in 7: number of RBs allocated.
- `Sym_Start` in 4: DMRS symbol index.
- `Sym_End` in 4: last data symbol index.
- `Rd_En` out 1: grid read strobe.
- `Rd_Sym` out 4: symbol index of the read.
- `Rd_Addr` out 11: subcarrier address of the read.
- `Rd_I`, `Rd_Q` in `Data_Len` (signed): read data, valid in the cycle after `Rd_En`.
- `Out_I`, `Out_Q` out `Data_Len` (signed): output sample.
- `Out_Valid` out 1: output sample is valid.
- `Out_Ready` in 1: consumer accepts the output sample.
- `Out_Is_DMRS` out 1: 1 for DMRS REs, 0 for data REs.
- `Out_Idx` out 11: RE index within the allocation for the current symbol.
- `Out_Sym` out 4: symbol index of the output RE.
- `Sym_Done` out 1: pulse when the last RE of a symbol is accepted at the output.
- `Dem_Done` out 1: pulse when the slot is complete.
- `Busy` out 1: high from the `Start` acceptance until the cycle `Dem_Done` pulses.
- `Cfg_Err` out 1: pulse when `Start` is rejected.

## Operation
- Configuration is latched on an accepted `Start`. Derived values:
  - `N_data = N_rb*12` (11 bits).
  - `N_dmrs = N_rb*6` (10 bits).
- Configuration check on `Start`. `Cfg_Err` pulses for 1 cycle and the block stays in IDLE if any of these holds:
  - `N_rb == 0`
  - `N_sc + N_data > 1200`, with the sum computed at 12 bits
  - `Sym_End < Sym_Start`
  - `Sym_End > 13`
- State machine: IDLE → RD_DMRS → RD_DATA → DRAIN → IDLE.
- RD_DMRS:
  - `Rd_Sym = Sym_Start`, `Rd_Addr = N_sc + 2k` for k = 0..N_dmrs−1 (even comb relative to `N_sc`, matching the mapper).
  - `Out_Is_DMRS = 1`, `Out_Idx = k`.
  - After the last read, go to RD_DATA if `Sym_End > Sym_Start`, otherwise go to DRAIN.
- RD_DATA:
  - For each symbol s = Sym_Start+1..Sym_End: `Rd_Addr = N_sc + k` for k = 0..N_data−1, `Out_Is_DMRS = 0`, `Out_Idx = k`.
  - Symbols run back-to-back with no idle cycle between them.
  - After the last read of `Sym_End`, go to DRAIN.
- DRAIN:
  - Wait until the output buffer is empty and no read is in flight.
  - Then pulse `Dem_Done`, drop `Busy` in the same cycle, and go to IDLE.
- Each read carries tag {`Out_Is_DMRS`, `Out_Idx`, `Out_Sym`, last-of-symbol} through the read pipeline alongside the data.
- Flow control (2-entry output buffer):
  - A read is issued only when `occupancy + in_flight − pop_this_cycle < 2`.
  - The buffer therefore never overflows, and with `Out_Ready` held high throughput is 1 RE/cycle.
- `Start` while `Busy` is ignored silently: no `Cfg_Err` and no effect.

## Timing
- Reset values:
  - All outputs 0, state IDLE, buffer empty.
  - An in-flight read is discarded.
  - Applies equally to reset asserted mid-slot.
- Latency, with `Start` sampled at edge t:
  - `Busy` is 1 from t+1.
  - First `Rd_En` in cycle t+1.
  - Data returns at t+2 and is written into the buffer at the end of t+2.
  - `Out_Valid = 1` in cycle t+3.
- Handshake:
  - A transfer occurs on a cycle with `Out_Valid && Out_Ready`.
  - Once `Out_Valid` is asserted, `Out_I`, `Out_Q` and the tags are held stable until the transfer.
- `Sym_Done` pulses in the same cycle as the transfer of the last RE of each symbol (DMRS symbol included).
- `Dem_Done` pulses no earlier than the cycle after the final transfer.
- Reads for the next symbol may overlap output of the previous one.

## Structure
- Shared package `re_pkg` holds:
  - `TOTAL_SC = 1200`, `SC_PER_RB = 12`, `DMRS_PER_RB = 6`
  - the state enum
  - the output tag struct
- Sub-module `re_demap_skid_fifo`: 2-entry FIFO holding data plus tag, with a combinational count output used for read credit.

## Test plan
- Basic slot: N_sc=100, N_rb=2, Sym_Start=2, Sym_End=4, `Out_Ready=1`.
  - DMRS reads: 12 reads at addresses 100, 102, …, 122.
  - Data reads: 24 reads per symbol at 100..123 for symbols 3 and 4.
  - Output: 60 transfers back-to-back, `Sym_Done` ×3, `Dem_Done` once; first `Out_Valid` at t+3.
- Backpressure: same configuration, `Out_Ready` random at 30%.
  - Output order and values are identical to the basic slot.
  - Never more than 2 REs are buffered or in flight.
  - No sample is lost or duplicated.
- Edge allocation: N_sc=1188, N_rb=1 is accepted, last address 1199. N_sc=1189, N_rb=1 gives a `Cfg_Err` pulse and `Busy` stays 0.
- DMRS-only slot: Sym_Start=Sym_End=5 gives only the 6·N_rb DMRS REs, one `Sym_Done`, then `Dem_Done`.
- Disturbances:
  - `Start` pulsed mid-slot has no effect.
  - `RST_DEM` asserted mid-RD_DATA: next cycle all outputs are 0 and the state is IDLE.
  - A fresh `Start` after reset completes normally.
